// File: rtl/psum_requant_pkg.sv
// Shared constants and state encoding for the psum requantizer.
package psum_requant_pkg;

    localparam int ACT_ZP  = 128;
    localparam int ACT_MIN = 0;
    localparam int ACT_MAX = 255;
    localparam int PROD_W  = 48;

    typedef enum logic [1:0] {
        ACC,
        QUANT,
        OUT
    } state_t;

endpackage

// File: rtl/psum_requant_core.sv
// Rounds, shifts, offsets and clamps a requant product into a zero-point-128 activation.
// Define PSUM_REQUANT_RELU_EN to raise the lower clamp bound to the zero point (ReLU).
module psum_requant_core
    import psum_requant_pkg::*;
#(
    parameter int SHIFT_W = 5
) (
    input  logic signed [PROD_W-1:0] prod,
    input  logic [SHIFT_W-1:0]       shift,
    output logic [7:0]               act,
    output logic                     sat
);

`ifdef PSUM_REQUANT_RELU_EN
    localparam int LO_BOUND = ACT_ZP;
`else
    localparam int LO_BOUND = ACT_MIN;
`endif

    // Two guard bits keep the rounding add and zero-point offset from overflowing.
    localparam int EXT_W = PROD_W + 2;

    logic signed [EXT_W-1:0] prod_ext;
    logic signed [EXT_W-1:0] half;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] biased;

    always_comb begin
        prod_ext = EXT_W'(prod);
        half     = '0;
        rounded  = prod_ext;
        if (shift != '0) begin
            half    = EXT_W'(1) << (shift - SHIFT_W'(1));
            rounded = (prod_ext + half) >>> shift;
        end
        biased = rounded + EXT_W'(ACT_ZP);
        act    = biased[7:0];
        sat    = 1'b0;
        if (biased > EXT_W'(ACT_MAX)) begin
            act = 8'(ACT_MAX);
            sat = 1'b1;
        end else if (biased < EXT_W'(LO_BOUND)) begin
            act = 8'(LO_BOUND);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/psum_requant.sv
// Accumulates ACC_LEN signed partial sums and requantizes each total to an 8-bit activation.
// Optional ReLU clamp is enabled with the PSUM_REQUANT_RELU_EN macro (see psum_requant_core).
module psum_requant
    import psum_requant_pkg::*;
#(
    parameter int ACC_LEN = 9,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_psum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_act,
    output logic               out_sat
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         count;
    logic [31:0]              acc;
    logic [SCALE_W-1:0]       scale_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_next;
    logic                     in_hs;
    logic                     last_hs;
    logic                     out_hs;
    logic [7:0]               core_act;
    logic                     core_sat;

    assign in_ready  = (state == ACC);
    assign in_hs     = in_valid && in_ready;
    assign last_hs   = in_hs && (count == LAST);
    assign out_hs    = out_valid && out_ready;
    // The scale is unsigned, so it is zero-extended before the signed multiply.
    assign prod_next = PROD_W'(signed'(acc)) * PROD_W'(signed'({1'b0, scale_q}));

    psum_requant_core #(
        .SHIFT_W(SHIFT_W)
    ) u_core (
        .prod (prod),
        .shift(shift_q),
        .act  (core_act),
        .sat  (core_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (last_hs) state_next = QUANT;
            QUANT:   state_next = OUT;
            OUT:     if (out_hs) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // OUT spends its first cycle registering the core result; out_valid rises after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            acc       <= '0;
            scale_q   <= '0;
            shift_q   <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
            out_act   <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (in_hs) begin
                acc   <= acc + in_psum;
                count <= last_hs ? '0 : count + CNT_W'(1);
            end
            if (last_hs) begin
                scale_q <= cfg_scale;
                shift_q <= cfg_shift;
            end
            if (state == QUANT) begin
                prod <= prod_next;
            end
            if ((state == OUT) && !out_valid) begin
                out_valid <= 1'b1;
                out_act   <= core_act;
                out_sat   <= core_sat;
            end
            if (out_hs) begin
                out_valid <= 1'b0;
                acc       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psum_requant.sv
// Self-checking bench for psum_requant: directed and randomized groups against an arithmetic model,
// on an ACC_LEN=3 instance plus a small ACC_LEN=1 instance.
module tb_psum_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_scale;
    logic [4:0]  cfg_shift;
    logic        in_valid, in_ready, out_valid, out_ready, out_sat;
    logic [31:0] in_psum;
    logic [7:0]  out_act;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_sat1;
    logic [31:0] in_psum1;
    logic [7:0]  out_act1;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    psum_requant #(.ACC_LEN(3), .SCALE_W(16), .SHIFT_W(5)) dut (
        .clk(clk), .rst(rst), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_sat(out_sat)
    );

    psum_requant #(.ACC_LEN(1), .SCALE_W(16), .SHIFT_W(5)) dut1 (
        .clk(clk), .rst(rst), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_psum(in_psum1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_act(out_act1), .out_sat(out_sat1)
    );

    // Reference: exact product, floor((prod + 2^(s-1)) / 2^s), offset by 128, clamp.
    function automatic void refModel(input int sum, input int unsigned scale, input int unsigned shift,
                                     output int act, output int sat);
        longint prod, num, divisor, r, v, lo;
        prod = longint'(sum) * longint'(scale);
        if (shift == 0) begin
            r = prod;
        end else begin
            divisor = longint'(1) << shift;
            num     = prod + divisor / 2;
            r       = num / divisor;
            if ((num % divisor != 0) && (num < 0)) r = r - 1;
        end
        v = r + 128;
`ifdef PSUM_REQUANT_RELU_EN
        lo = 128;
`else
        lo = 0;
`endif
        if (v > 255) begin
            act = 255; sat = 1;
        end else if (v < lo) begin
            act = int'(lo); sat = 1;
        end else begin
            act = int'(v); sat = 0;
        end
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic sendPsum(input int value);
        int waitCycles;
        @(negedge clk);
        in_valid   = 1'b1;
        in_psum    = value;
        waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", in_ready, 1);
        @(posedge clk);
    endtask

    // One full group: cfg is only meaningful on the last psum, junk input is offered while busy.
    task automatic applyStimulus(input int p0, input int p1, input int p2, input int scale,
                                 input int shift, input int hold, input string tag);
        int expAct, expSat;
        refModel(p0 + p1 + p2, scale, shift, expAct, expSat);
        out_ready = (hold == 0);
        cfg_scale = 16'($urandom);
        cfg_shift = 5'($urandom);
        sendPsum(p0);
        sendPsum(p1);
        cfg_scale = 16'(scale);
        cfg_shift = 5'(shift);
        sendPsum(p2);
        @(negedge clk);
        in_psum   = $urandom;
        cfg_scale = 16'($urandom);
        cfg_shift = 5'($urandom);
        checkOutput({tag, "_valid_t1"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_valid_t2"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_in_ready_busy"}, in_ready, 0);
        checkOutput({tag, "_act"}, out_act, expAct);
        checkOutput({tag, "_sat"}, out_sat, expSat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, out_valid, 1);
            checkOutput({tag, "_hold_act"}, out_act, expAct);
            checkOutput({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_valid_after"}, out_valid, 0);
        checkOutput({tag, "_in_ready_after"}, in_ready, 1);
        checkOutput({tag, "_act_kept"}, out_act, expAct);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a, b, c, sc, sh, expAct, expSat, v;
        rst = 1'b1; in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;
        cfg_scale = '0; cfg_shift = '0;
        in_valid1 = 1'b0; in_psum1 = '0; out_ready1 = 1'b1;
        #1;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_act", out_act, 0);
        checkOutput("reset_sat", out_sat, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(10, 20, 30, 3, 2, 0, "basic");
        applyStimulus(100, 200, -50, 1, 0, 0, "clamp_hi");
        applyStimulus(-600, -300, -100, 1, 0, 0, "clamp_lo");
        applyStimulus(2, 2, 2, 1, 2, 0, "round_pos");
        applyStimulus(-2, -2, -2, 1, 2, 0, "round_neg");
        applyStimulus(-20, -20, -20, 1, 0, 0, "relu_case");
        applyStimulus(7, 8, 9, 2, 1, 5, "backpressure");
        applyStimulus(1, 2, 3, 1, 0, 0, "after_bp");

        // Reset with two of three psums accumulated: the partial sum must be lost.
        sendPsum(50);
        sendPsum(60);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_partial_valid", out_valid, 0);
        checkOutput("rst_partial_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 1, 0, 0, "rst_partial");

        // Reset while an activation is being held must drop it without waiting for a clock.
        out_ready = 1'b0;
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        sendPsum(5);
        sendPsum(5);
        sendPsum(5);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_hold_pre_valid", out_valid, 1);
        checkOutput("rst_hold_pre_act", out_act, 143);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_hold_valid", out_valid, 0);
        checkOutput("rst_hold_act", out_act, 0);
        checkOutput("rst_hold_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1, 1, 1, 1, 0, 0, "rst_hold");

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom); b = int'($urandom); c = int'($urandom);
            end else begin
                a = int'($urandom_range(0, 2000)) - 1000;
                b = int'($urandom_range(0, 2000)) - 1000;
                c = int'($urandom_range(0, 2000)) - 1000;
            end
            sc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 65535));
            sh = int'($urandom_range(0, 31));
            applyStimulus(a, b, c, sc, sh, int'($urandom_range(0, 2)), "random");
        end

        // ACC_LEN=1: every psum is its own complete sum.
        for (int k = 0; k < 4; k++) begin
            v  = int'($urandom_range(0, 600)) - 300;
            sc = int'($urandom_range(1, 4));
            sh = int'($urandom_range(0, 3));
            refModel(v, sc, sh, expAct, expSat);
            @(negedge clk);
            in_valid1 = 1'b1;
            in_psum1  = v;
            cfg_scale = 16'(sc);
            cfg_shift = 5'(sh);
            checkOutput("len1_in_ready", in_ready1, 1);
            @(negedge clk);
            in_valid1 = 1'b0;
            cfg_scale = 16'($urandom);
            checkOutput("len1_valid_t1", out_valid1, 0);
            @(negedge clk);
            checkOutput("len1_valid_t2", out_valid1, 0);
            @(negedge clk);
            checkOutput("len1_valid", out_valid1, 1);
            checkOutput("len1_act", out_act1, expAct);
            checkOutput("len1_sat", out_sat1, expSat);
            @(negedge clk);
            checkOutput("len1_valid_after", out_valid1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
